// File: rtl/fc_output_collector.sv
// fc_output_collector
//   Output stage of the FC layer controller. Each set_output pulse captures a
//   tile of TILING_SIZE partial sums, adds the per-lane bias, rescales by
//   FRAC_SHIFT and saturates to OUT_W bits. Up to two tiles are held in a
//   ping-pong buffer and streamed one lane per beat over valid/ready.
//   Optional build macro: FC_RELU_EN (clamps negative results to zero).
module fc_output_collector #(
    parameter int TILING_SIZE = 8,
    parameter int KERNEL_SIZE = 4096,
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 8,
    parameter int FRAC_SHIFT  = 8
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         set_output,
    input  logic [TILING_SIZE*ACC_W-1:0] psum_in,
    input  logic [TILING_SIZE*ACC_W-1:0] bias_in,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         done,
    output logic                         overflow,
    output logic [15:0]                  tile_cnt
);

    localparam int NUM_TILES = KERNEL_SIZE / TILING_SIZE;
    localparam int LANE_W    = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Saturation bounds expressed at the widened sum width
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0]  r_slot [2][TILING_SIZE];
    logic [1:0]        r_slot_last;
    logic [1:0]        r_occ;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [LANE_W-1:0] r_lane_idx;
    logic [15:0]       r_tile_cnt;
    logic              r_overflow;
    logic              r_done;
    logic [0:0]        r_state;

    logic w_xfer;
    logic w_lane_last;
    logic w_free;
    logic w_capture;
    logic w_drop;
    logic w_tile_is_last;

    // Bias add, arithmetic rescale and saturation for one lane
    function automatic logic [OUT_W-1:0] f_scale(input logic [ACC_W-1:0] p,
                                                 input logic [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        logic signed [ACC_W:0] r;
        logic        [OUT_W-1:0] res;
        s = $signed({p[ACC_W-1], p}) + $signed({b[ACC_W-1], b});
        r = s >>> FRAC_SHIFT;
        if (r > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = r[OUT_W-1:0];
        end
`ifdef FC_RELU_EN
        if (res[OUT_W-1]) begin
            res = '0;
        end
`endif
        return res;
    endfunction

    // Handshake and capture decisions; a full buffer still accepts a tile when
    // the read slot frees in the same cycle
    always_comb begin
        w_xfer         = out_valid & out_ready;
        w_lane_last    = (r_lane_idx == LANE_W'(TILING_SIZE - 1));
        w_free         = w_xfer & w_lane_last;
        w_capture      = set_output & ~start & ((r_occ != 2'd2) | w_free);
        w_drop         = set_output & ~start & ~w_capture;
        w_tile_is_last = (r_tile_cnt == 16'(NUM_TILES - 1));
    end

    // Output view of the read slot; data forced to zero when idle
    always_comb begin
        out_valid = (r_state == ST_DRAIN);
        out_data  = out_valid ? r_slot[r_rd_ptr][r_lane_idx] : '0;
        out_last  = out_valid & r_slot_last[r_rd_ptr] & w_lane_last;
    end

    assign done     = r_done;
    assign overflow = r_overflow;
    assign tile_cnt = r_tile_cnt;

    // Slot storage: scaled lanes and the last-tile tag are written at capture
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < TILING_SIZE; i++) begin
                    r_slot[s][i] <= '0;
                end
            end
            r_slot_last <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < TILING_SIZE; i++) begin
                r_slot[r_wr_ptr][i] <= f_scale(psum_in[i*ACC_W +: ACC_W],
                                               bias_in[i*ACC_W +: ACC_W]);
            end
            r_slot_last[r_wr_ptr] <= w_tile_is_last;
        end
    end

    // Occupancy, pointers, lane index and the EMPTY/DRAIN state
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_lane_idx <= '0;
            r_state    <= ST_EMPTY;
        end else if (start) begin
            r_occ      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_lane_idx <= '0;
            r_state    <= ST_EMPTY;
        end else begin
            case ({w_capture, w_free})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_capture) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_xfer) begin
                r_lane_idx <= w_lane_last ? '0 : r_lane_idx + LANE_W'(1);
            end
            if (w_free) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case (r_state)
                ST_EMPTY: if (w_capture) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_free && !w_capture && r_occ == 2'd1) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Layer bookkeeping: tile counter, sticky overflow and the done pulse
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_tile_cnt <= 16'd0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_xfer & out_last;
            if (start) begin
                r_tile_cnt <= 16'd0;
                r_overflow <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_tile_cnt <= w_tile_is_last ? 16'd0 : r_tile_cnt + 16'd1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_output_collector.sv
// tb_fc_output_collector
//   Scoreboard bench: expected lanes are queued when a tile is driven and
//   popped as beats transfer. Built with KERNEL_SIZE=32 so a layer is 4 tiles.
module tb_fc_output_collector;

    localparam int TS = 8;
    localparam int KS = 32;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int FS = 8;
    localparam int NT = KS / TS;

    typedef logic signed [AW-1:0] lane_arr_t [TS];
    typedef struct {
        logic signed [OW-1:0] data;
        logic                 last;
    } beat_t;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              start;
    logic              set_output;
    logic [TS*AW-1:0]  psum_in;
    logic [TS*AW-1:0]  bias_in;
    logic [OW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic              overflow;
    logic [15:0]       tile_cnt;

    beat_t     sb[$];
    beat_t     popped;
    int        compared   = 0;
    int        mismatched = 0;
    int        benchTile  = 0;
    logic      donePending = 1'b0;
    lane_arr_t pA, bA;

    fc_output_collector #(
        .TILING_SIZE(TS), .KERNEL_SIZE(KS), .ACC_W(AW), .OUT_W(OW), .FRAC_SHIFT(FS)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .set_output(set_output),
        .psum_in(psum_in), .bias_in(bias_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .done(done), .overflow(overflow), .tile_cnt(tile_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference lane: exact sum, floor division by 2^FS, clamp
    function automatic logic signed [OW-1:0] model(input logic signed [AW-1:0] p,
                                                   input logic signed [AW-1:0] b);
        longint s, q;
        s = longint'(p) + longint'(b);
        q = s / 256;
        if ((s % 256 != 0) && (s < 0)) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`ifdef FC_RELU_EN
        if (q < 0) q = 0;
`endif
        return q[OW-1:0];
    endfunction

    task automatic applyStimulus(input lane_arr_t p, input lane_arr_t b, input bit expectAccept);
        beat_t e;
        for (int i = 0; i < TS; i++) begin
            psum_in[i*AW +: AW] = p[i];
            bias_in[i*AW +: AW] = b[i];
        end
        set_output = 1'b1;
        if (expectAccept) begin
            for (int i = 0; i < TS; i++) begin
                e.data = model(p[i], b[i]);
                e.last = (benchTile == NT - 1) && (i == TS - 1);
                sb.push_back(e);
            end
            benchTile = (benchTile + 1) % NT;
        end
        @(posedge clk1); #1;
        set_output = 1'b0;
    endtask

    task automatic randomTile(output lane_arr_t p, output lane_arr_t b);
        for (int i = 0; i < TS; i++) begin
            p[i] = $urandom;
            b[i] = $signed(AW'($urandom_range(0, 4095))) - 2048;
        end
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        benchTile = 0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk1); #1;
        end
        checkOutput("drainTimeout", sb.size(), 0);
    endtask

    // Monitor: transfers are sampled on the falling edge, done one beat later
    always @(negedge clk1) begin
        if (!rst_n) begin
            donePending = 1'b0;
        end else begin
            checkOutput("done", done, donePending);
            donePending = 1'b0;
            if (out_valid && out_ready) begin
                checkOutput("beatExpected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    popped = sb.pop_front();
                    checkOutput("data", $signed(out_data), popped.data);
                    checkOutput("last", out_last, popped.last);
                    donePending = popped.last;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; set_output = 1'b0; out_ready = 1'b1;
        psum_in = '0; bias_in = '0;
        repeat (2) @(posedge clk1); #1;
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstData", out_data, 0);
        checkOutput("rstLast", out_last, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstOverflow", overflow, 0);
        checkOutput("rstTileCnt", tile_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk1); #1;

        // Single tile, lane i gives i
        for (int i = 0; i < TS; i++) begin
            pA[i] = i * 256;
            bA[i] = 0;
        end
        applyStimulus(pA, bA, 1'b1);
        checkOutput("latencyValid", out_valid, 1);
        waitDrain();
        checkOutput("tileCntT1", tile_cnt, 1);

        // Saturation corners
        randomTile(pA, bA);
        pA[0] = 32'h7FFFFFFF; bA[0] = 1;
        pA[1] = 32'h80000000; bA[1] = -1;
        pA[2] = -1280;        bA[2] = 0;
        applyStimulus(pA, bA, 1'b1);
        waitDrain();
        checkOutput("tileCntT2", tile_cnt, 2);

        // Backpressure with a dropped third tile
        doStart();
        checkOutput("startOverflow", overflow, 0);
        checkOutput("startTileCnt", tile_cnt, 0);
        out_ready = 1'b0;
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b0);
        repeat (5) @(posedge clk1); #1;
        checkOutput("bpTileCnt", tile_cnt, 2);
        checkOutput("bpOverflow", overflow, 1);
        checkOutput("bpValid", out_valid, 1);
        checkOutput("bpFrozenData", $signed(out_data), sb[0].data);
        out_ready = 1'b1;
        waitDrain();
        checkOutput("bpOverflowSticky", overflow, 1);

        // Capture coinciding with the lane 7 transfer of a full buffer
        doStart();
        checkOutput("start2Overflow", overflow, 0);
        out_ready = 1'b0;
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        out_ready = 1'b1;
        repeat (7) @(posedge clk1); #1;
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        checkOutput("simulOverflow", overflow, 0);
        checkOutput("simulTileCnt", tile_cnt, 3);
        waitDrain();

        // Fourth tile ends the layer: out_last, done, counter wrap
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        waitDrain();
        repeat (3) @(posedge clk1); #1;
        checkOutput("layerTileCnt", tile_cnt, 0);
        checkOutput("layerIdle", out_valid, 0);

        // Reset while lane 3 is presented
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        repeat (3) @(posedge clk1); #1;
        checkOutput("preRstTileCnt", tile_cnt, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        benchTile = 0;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstData", out_data, 0);
        checkOutput("midRstLast", out_last, 0);
        checkOutput("midRstTileCnt", tile_cnt, 0);
        @(posedge clk1); #1;
        rst_n = 1'b1;
        @(posedge clk1); #1;
        checkOutput("postRstValid", out_valid, 0);

        // Fresh tile after reset
        randomTile(pA, bA); applyStimulus(pA, bA, 1'b1);
        waitDrain();
        repeat (2) @(posedge clk1); #1;
        checkOutput("leftover", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
